// File: rtl/mont_convert_if.sv
// Request/response bundle for the Montgomery-domain converter.
// The requester drives start/dir/a/n; the converter drives result/busy/done.
interface mont_convert_if #(
  parameter int WIDTH = 1024
);
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output start, dir, a, n,
    input  result, busy, done
  );

  modport slave (
    input  start, dir, a, n,
    output result, busy, done
  );
endinterface

// File: rtl/mont_convert.sv
// Bit-serial converter between the residue domain and the Montgomery domain
// (R = 2^WIDTH). dir=0 computes a*R mod n by WIDTH modular doublings;
// dir=1 computes a*R^-1 mod n by WIDTH exact modular halvings.
// One conversion takes WIDTH steps after the accept edge. The running value
// stays below n after every step, so no final reduction state is needed.
module mont_convert #(
  parameter int WIDTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  mont_convert_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] n_q;
  logic             dir_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;

  // Step datapath; one extra bit keeps the carry when n has its MSB set.
  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   dbl_sub;
  logic [WIDTH:0]   dbl_red;
  logic             dbl_ge;
  logic [WIDTH:0]   half_sum;
  logic [WIDTH-1:0] x_d;
  logic             last_step;
  logic             unused_bits;

  // Next running value: modular double (into domain) or exact halving (out).
  always_comb begin
    dbl      = {x_q, 1'b0};
    dbl_ge   = (dbl >= {1'b0, n_q});
    dbl_sub  = dbl - {1'b0, n_q};
    dbl_red  = dbl_ge ? dbl_sub : dbl;
    // n is odd, so adding it to an odd x makes the sum even.
    half_sum = {1'b0, x_q} + (x_q[0] ? {1'b0, n_q} : {(WIDTH + 1){1'b0}});
    if (dir_q) begin
      x_d = half_sum[WIDTH:1];
    end else begin
      x_d = dbl_red[WIDTH-1:0];
    end
  end

  // The step that moves the counter to WIDTH is the final one.
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // Reduced values fit in WIDTH bits and the halving drops bit 0.
  assign unused_bits = ^{dbl_red[WIDTH], half_sum[0]};

  // Control FSM with registered outputs; reset aborts any conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      n_q      <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_q     <= bus.a;
            n_q     <= bus.n;
            dir_q   <= bus.dir;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ITER;
          end
        end
        ITER: begin
          x_q   <= x_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            result_q <= x_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_mont_convert.sv
// Self-checking bench for mont_convert: directed WIDTH=8 vectors and
// corner sequences, plus a randomized WIDTH=64 cross-check against a
// plain-arithmetic model of a*R mod n and a*R^-1 mod n.
module tb_mont_convert;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8;
  logic rst64;

  mont_convert_if #(.WIDTH(8))  bus8 ();
  mont_convert_if #(.WIDTH(64)) bus64 ();

  mont_convert #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8)
  );

  mont_convert #(.WIDTH(64)) dut64 (
    .clk (clk),
    .rst (rst64),
    .bus (bus64)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] n;
    logic       dir;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // a * 2^64 mod n
  function automatic logic [63:0] model_into(input logic [63:0] a, input logic [63:0] n);
    logic [127:0] t;
    logic [127:0] m;
    t = {a, 64'd0};
    m = {64'd0, n};
    t = t % m;
    return t[63:0];
  endfunction

  // a * (2^-1)^64 mod n, with 2^-1 = (n+1)/2 for odd n
  function automatic logic [63:0] model_out(input logic [63:0] a, input logic [63:0] n);
    logic [127:0] m;
    logic [127:0] inv2;
    logic [127:0] rinv;
    logic [127:0] r;
    m    = {64'd0, n};
    inv2 = {64'd0, (n >> 1) + 64'd1};
    rinv = 128'd1;
    for (int k = 0; k < 64; k++) rinv = (rinv * inv2) % m;
    r = ({64'd0, a} * rinv) % m;
    return r[63:0];
  endfunction

  // Called #1 after an edge with the 8-bit DUT idle; returns result and edges to done.
  task automatic run8(input logic [7:0] a, input logic [7:0] n, input logic d,
                      output logic [7:0] res, output int lat);
    bus8.a = a; bus8.n = n; bus8.dir = d; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus8.done) break;
    end
    res = bus8.result;
  endtask

  task automatic run64(input logic [63:0] a, input logic [63:0] n, input logic d,
                       output logic [63:0] res, output int lat);
    bus64.a = a; bus64.n = n; bus64.dir = d; bus64.start = 1'b1;
    @(posedge clk); #1;
    bus64.start = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus64.done) break;
    end
    res = bus64.result;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[9];
    logic [7:0] r8;
    logic [63:0] r64, r64b, a64, n64, b64;
    int         lat;
    int         done_at[$];

    vecs[0] = '{a: 8'd5,   n: 8'd13,  dir: 1'b0, exp: 8'd6};
    vecs[1] = '{a: 8'd6,   n: 8'd13,  dir: 1'b1, exp: 8'd5};
    vecs[2] = '{a: 8'd1,   n: 8'd13,  dir: 1'b1, exp: 8'd3};
    vecs[3] = '{a: 8'd1,   n: 8'd13,  dir: 1'b0, exp: 8'd9};
    vecs[4] = '{a: 8'd0,   n: 8'd13,  dir: 1'b0, exp: 8'd0};
    vecs[5] = '{a: 8'd0,   n: 8'd13,  dir: 1'b1, exp: 8'd0};
    vecs[6] = '{a: 8'd250, n: 8'd251, dir: 1'b0, exp: 8'd246};
    vecs[7] = '{a: 8'd246, n: 8'd251, dir: 1'b1, exp: 8'd250};
    vecs[8] = '{a: 8'd254, n: 8'd255, dir: 1'b0, exp: 8'd254};

    rst8 = 1'b1; rst64 = 1'b1;
    bus8.start = 1'b0;  bus8.dir = 1'b0;  bus8.a = '0;  bus8.n = '0;
    bus64.start = 1'b0; bus64.dir = 1'b0; bus64.a = '0; bus64.n = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result8", {56'd0, bus8.result}, 64'd0);
    check("reset busy8",   {63'd0, bus8.busy},   64'd0);
    check("reset done8",   {63'd0, bus8.done},   64'd0);
    check("reset result64", bus64.result, 64'd0);
    rst8 = 1'b0; rst64 = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, each with latency and one-cycle done pulse checks.
    for (int v = 0; v < 9; v++) begin
      run8(vecs[v].a, vecs[v].n, vecs[v].dir, r8, lat);
      check($sformatf("vec%0d a=%0d n=%0d dir=%0d result", v, vecs[v].a, vecs[v].n, vecs[v].dir),
            {56'd0, r8}, {56'd0, vecs[v].exp});
      check($sformatf("vec%0d latency", v), 64'(lat), 64'd8);
      check($sformatf("vec%0d busy at done", v), {63'd0, bus8.busy}, 64'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d done cleared", v), {63'd0, bus8.done}, 64'd0);
    end

    // Start pulsed mid-conversion with different operands must be ignored.
    bus8.a = 8'd5; bus8.n = 8'd13; bus8.dir = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    done_at.delete();
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      bus8.start = 1'b0;
      if (e == 3) begin
        bus8.a = 8'd7; bus8.n = 8'd11; bus8.dir = 1'b1; bus8.start = 1'b1;
      end
      if (bus8.done) begin
        done_at.push_back(e);
        check("ignored-start result", {56'd0, bus8.result}, 64'd6);
      end
    end
    check("ignored-start done count", 64'(done_at.size()), 64'd1);
    if (done_at.size() > 0) check("ignored-start done edge", 64'(done_at[0]), 64'd8);

    // start held high: back-to-back conversions every 9 cycles.
    bus8.a = 8'd1; bus8.n = 8'd13; bus8.dir = 1'b0; bus8.start = 1'b1;
    done_at.delete();
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 4) check("result stable while busy", {56'd0, bus8.result}, 64'd6);
      if (bus8.done) begin
        done_at.push_back(e);
        check($sformatf("held-start result @%0d", e), {56'd0, bus8.result}, 64'd9);
      end
    end
    bus8.start = 1'b0;
    check("held-start done count", 64'(done_at.size()), 64'd3);
    if (done_at.size() == 3) begin
      check("held-start first done", 64'(done_at[0]), 64'd9);
      check("held-start interval 1", 64'(done_at[1] - done_at[0]), 64'd9);
      check("held-start interval 2", 64'(done_at[2] - done_at[1]), 64'd9);
    end
    for (int i = 0; i < 20 && bus8.busy; i++) begin
      @(posedge clk); #1;
    end
    check("idle after held-start", {63'd0, bus8.busy}, 64'd0);

    // Asynchronous reset at step 4 clears everything without a clock edge.
    bus8.a = 8'd5; bus8.n = 8'd13; bus8.dir = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst8 = 1'b1;
    #1;
    check("async rst result", {56'd0, bus8.result}, 64'd0);
    check("async rst busy",   {63'd0, bus8.busy},   64'd0);
    check("async rst done",   {63'd0, bus8.done},   64'd0);
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(posedge clk); #1;
    run8(8'd5, 8'd13, 1'b0, r8, lat);
    check("post-reset result", {56'd0, r8}, 64'd6);
    check("post-reset latency", 64'(lat), 64'd8);

    // Randomized WIDTH=64 cross-check and round trip.
    for (int i = 0; i < 16; i++) begin
      n64 = {$urandom(), $urandom()} | 64'd1;
      if (i % 4 == 0) n64[63] = 1'b1;
      if (n64 == 64'd1) n64 = 64'd3;
      a64 = {$urandom(), $urandom()} % n64;
      if (i == 0) a64 = n64 - 64'd1;
      b64 = {$urandom(), $urandom()} % n64;

      run64(a64, n64, 1'b0, r64, lat);
      check($sformatf("rand%0d into n=%0h a=%0h", i, n64, a64), r64, model_into(a64, n64));
      check($sformatf("rand%0d into latency", i), 64'(lat), 64'd64);
      @(posedge clk); #1;
      run64(r64, n64, 1'b1, r64b, lat);
      check($sformatf("rand%0d round trip", i), r64b, a64);
      @(posedge clk); #1;
      run64(b64, n64, 1'b1, r64, lat);
      check($sformatf("rand%0d out n=%0h b=%0h", i, n64, b64), r64, model_out(b64, n64));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
